mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Parametrised main control FSM for the multicycle ARM datapath. It is the successor of the current main FSM and keeps its state encodings and control-word layout. It adds:
- a configurable-latency multiply sequence, including long multiply that writes two registers;
- optional memory wait handshaking on fetch, load and store;
- an illegal-instruction flag.

It sits in the controller beside the decoder and condition logic and drives the datapath control strobes.

## Interface
Parameters:
- MUL_CYCLES, 1, execute cycles of the multiplier (legal 1..15).
- MEM_WAIT_EN, 0, 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction op field.
- Funct  in  6  instruction funct field; [5]=I, [0]=L.
- is_mul  in  1  decoded multiply instruction.
- is_long  in  1  decoded long multiply (UMULL/SMULL); valid when is_mul=1.
- mem_ready  in  1  memory completes access this cycle.
- IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath strobes.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects.
- MulStart  out  1  one-cycle pulse launching the multiplier.
- MulHi  out  1  selects high product word and RdHi destination.
- Illegal  out  1  high while in UNKNOWN.
- state_o  out  4  current state, debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, UNKNOWN 10, MULEX 11, MULWB 12, MULWBHI 13. Codes 14 and 15 go to FETCH.
- Transitions:
  - FETCH→DECODE when mem_ready, otherwise hold.
  - DECODE→MULEX if is_mul (this takes priority over Op). Otherwise:
    - Op=00: EXECUTEI if Funct[5], else EXECUTER.
    - Op=01: MEMADR.
    - Op=10: BRANCH.
    - Op=11: UNKNOWN.
  - MEMADR→MEMREAD if Funct[0], else MEMWRITE.
  - MEMREAD→MEMWB when mem_ready, otherwise hold.
  - MEMWRITE→FETCH when mem_ready, otherwise hold.
  - MEMWB, ALUWB, BRANCH and UNKNOWN→FETCH.
  - EXECUTER/EXECUTEI→ALUWB.
  - MULEX→MULWB once the counter reaches MUL_CYCLES-1.
  - MULWB→MULWBHI if long_q, else FETCH.
  - MULWBHI→FETCH.
- long_q is a register loaded from is_long in DECODE.
- Outputs are Moore functions of state; any field not listed below is 0.
  - FETCH: IRWrite=1 and NextPC=1, both gated by mem_ready; ResultSrc=10, ALUSrcA=01, ALUSrcB=10.
  - DECODE: ResultSrc=10, ALUSrcA=01, ALUSrcB=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: RegW=1, ResultSrc=01.
  - MEMWRITE: MemW=1 and AdrSrc=1 on every held cycle.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: Branch=1, ResultSrc=10, ALUSrcB=01.
  - MULEX: ALUOp=1; MulStart=1 on the first MULEX cycle only.
  - MULWB: RegW=1, MulHi=0.
  - MULWBHI: RegW=1, MulHi=1.
  - UNKNOWN: Illegal=1.
- Cycle counter: 4 bits. Cleared on MULEX entry, increments in MULEX, saturates at MUL_CYCLES-1.

## Timing
- Reset (low): state=FETCH, counter=0, long_q=0. Outputs then show FETCH decode, with IRWrite/NextPC following mem_ready (always 1 when MEM_WAIT_EN=0).
- Reset asserted mid-operation aborts immediately to FETCH; no write strobe is issued after reset rises.
- Instruction latency with zero memory wait:
  - branch: 3 cycles;
  - data-processing: 4 cycles;
  - store: 4 cycles;
  - load: 5 cycles;
  - multiply: 3+MUL_CYCLES cycles;
  - long multiply: 4+MUL_CYCLES cycles;
  - illegal: 3 cycles.
- Each wait cycle (mem_ready=0) in FETCH/MEMREAD/MEMWRITE adds exactly one cycle. Outputs stay stable while held, except that IRWrite and NextPC stay 0 until mem_ready.
- MUL_CYCLES=1: MULEX lasts one cycle; MulStart and the exit to MULWB occur in that same cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - the state encoding constants (4-bit);
  - the control-word field order {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  - the ResultSrc/ALUSrc select constants.
- Sub-module mc_cycle_counter: loadable saturating 4-bit counter with clear, increment and done (count==limit-1) outputs. It is instantiated for MULEX.

## Test plan
- Reset low mid-MEMWRITE with MEM_WAIT_EN=1 -> state_o=0 immediately and MemW=0; after release, FETCH then DECODE.
- Data-processing register op (Op=00, Funct[5]=0) -> states 0,1,6,8,0; RegW=1 only in the ALUWB cycle.
- LDR with MEM_WAIT_EN=1 and mem_ready low for 2 cycles in MEMREAD -> state 3 held 3 cycles; RegW=1 once, in MEMWB with ResultSrc=01.
- Multiply with MUL_CYCLES=4, is_long=1 -> MULEX for 4 cycles, MulStart only on the first; MULWB (MulHi=0) then MULWBHI (MulHi=1); RegW high for 2 cycles total.
- Op=11 -> state 10 for one cycle with Illegal=1 and RegW=MemW=0, then FETCH.
- MUL_CYCLES=1 multiply -> states 0,1,11,12,0 with MulStart=1 in the single MULEX cycle.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle main control FSM.
//   - state encodings (4-bit, kept from the previous main FSM)
//   - control-word layout {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc,
//     ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
//   - ResultSrc / ALUSrcA / ALUSrcB select constants
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10,
    S_MULEX    = 4'd11,
    S_MULWB    = 4'd12,
    S_MULWBHI  = 4'd13
  } state_e;

  // Control word, MSB first in the historical field order.
  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       mem_w;
    logic       reg_w;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(13'd0);

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALUSrcA selects
  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: decoder/memory inputs and datapath strobes of the main FSM.
//   master: decoder/datapath side (drives instruction fields and mem_ready)
//   slave : the FSM (drives strobes, mux selects, multiply controls, debug)
interface mc_ctrl_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       is_mul;
  logic       is_long;
  logic       mem_ready;

  logic       IRWrite;
  logic       AdrSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       MulStart;
  logic       MulHi;
  logic       Illegal;
  logic [3:0] state_o;

  modport master (
    output Op, Funct, is_mul, is_long, mem_ready,
    input  IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
           ALUSrcA, ALUSrcB, ResultSrc, MulStart, MulHi, Illegal, state_o
  );

  modport slave (
    input  Op, Funct, is_mul, is_long, mem_ready,
    output IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
           ALUSrcA, ALUSrcB, ResultSrc, MulStart, MulHi, Illegal, state_o
  );
endinterface

// File: rtl/mc_ctrl_fsm_cycle_counter.sv
// mc_cycle_counter: 4-bit saturating cycle counter.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (priority over increment)
//   inc_i      : increment, holds once count reaches limit_i-1
//   limit_i    : cycle limit loaded by the user
//   count_o    : current count
//   done_o     : count_o == limit_i-1
module mc_cycle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [3:0] limit_i,
  output logic [3:0] count_o,
  output logic       done_o
);
  logic [3:0] count_q, count_d;
  logic [3:0] last_s;

  assign last_s  = limit_i - 4'd1;
  assign done_o  = (count_q == last_s);
  assign count_o = count_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (inc_i && !done_o) begin
      count_d = count_q + 4'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 4'd0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main control FSM of the multicycle ARM datapath.
//   Params : MUL_CYCLES (1..15) multiplier execute cycles,
//            MEM_WAIT_EN (1 = memory states wait for mem_ready).
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : mc_ctrl_fsm_if.slave (decoder inputs, mem_ready, strobes,
//            MulStart/MulHi, Illegal, state_o)
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES  = 1,
  parameter int MEM_WAIT_EN = 0
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.slave  bus
);
  localparam logic [3:0] MUL_LIMIT = 4'(MUL_CYCLES);

  state_e     state_q, state_d;
  logic       long_q, long_d;
  ctrl_t      ctrl_s;
  logic       mul_start_s, mul_hi_s, illegal_s;
  logic       rdy_s;
  logic       in_mulex_s;
  logic       cnt_done_s;
  logic [3:0] cnt_s;

  // With waits disabled every memory access completes in one cycle.
  assign rdy_s      = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;
  assign in_mulex_s = (state_q == S_MULEX);

  // Counter is held at zero outside MULEX, so it reads 0 on the first MULEX cycle.
  mc_cycle_counter u_mul_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (!in_mulex_s),
    .inc_i   (in_mulex_s),
    .limit_i (MUL_LIMIT),
    .count_o (cnt_s),
    .done_o  (cnt_done_s)
  );

  // State and long-multiply flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      long_q  <= long_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    if (state_q == S_DECODE) long_d = bus.is_long;
    else                     long_d = long_q;
    case (state_q)
      S_FETCH:    state_d = rdy_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (bus.is_mul) begin
          state_d = S_MULEX;
        end else begin
          case (bus.Op)
            2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_UNKNOWN;
          endcase
        end
      end
      S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = rdy_s ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = rdy_s ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_MULEX:    state_d = cnt_done_s ? S_MULWB : S_MULEX;
      S_MULWB:    state_d = long_q ? S_MULWBHI : S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH, S_UNKNOWN, S_MULWBHI: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode (IRWrite/NextPC additionally gated by memory ready).
  always_comb begin
    ctrl_s      = CTRL_IDLE;
    mul_start_s = 1'b0;
    mul_hi_s    = 1'b0;
    illegal_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl_s.ir_write   = rdy_s;
        ctrl_s.next_pc    = rdy_s;
        ctrl_s.result_src = RES_ALU;
        ctrl_s.alu_src_a  = SRCA_PC;
        ctrl_s.alu_src_b  = SRCB_FOUR;
      end
      S_DECODE: begin
        ctrl_s.result_src = RES_ALU;
        ctrl_s.alu_src_a  = SRCA_PC;
        ctrl_s.alu_src_b  = SRCB_FOUR;
      end
      S_MEMADR:   ctrl_s.alu_src_b = SRCB_IMM;
      S_MEMREAD:  ctrl_s.adr_src   = 1'b1;
      S_MEMWB: begin
        ctrl_s.reg_w      = 1'b1;
        ctrl_s.result_src = RES_DATA;
      end
      S_MEMWRITE: begin
        ctrl_s.mem_w   = 1'b1;
        ctrl_s.adr_src = 1'b1;
      end
      S_EXECUTER: ctrl_s.alu_op = 1'b1;
      S_EXECUTEI: begin
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = 1'b1;
      end
      S_ALUWB:    ctrl_s.reg_w = 1'b1;
      S_BRANCH: begin
        ctrl_s.branch     = 1'b1;
        ctrl_s.result_src = RES_ALU;
        ctrl_s.alu_src_b  = SRCB_IMM;
      end
      S_MULEX: begin
        ctrl_s.alu_op = 1'b1;
        mul_start_s   = (cnt_s == 4'd0);
      end
      S_MULWB:    ctrl_s.reg_w = 1'b1;
      S_MULWBHI: begin
        ctrl_s.reg_w = 1'b1;
        mul_hi_s     = 1'b1;
      end
      S_UNKNOWN:  illegal_s = 1'b1;
      default:    ctrl_s = CTRL_IDLE;
    endcase
  end

  assign bus.NextPC    = ctrl_s.next_pc;
  assign bus.Branch    = ctrl_s.branch;
  assign bus.MemW      = ctrl_s.mem_w;
  assign bus.RegW      = ctrl_s.reg_w;
  assign bus.IRWrite   = ctrl_s.ir_write;
  assign bus.AdrSrc    = ctrl_s.adr_src;
  assign bus.ResultSrc = ctrl_s.result_src;
  assign bus.ALUSrcA   = ctrl_s.alu_src_a;
  assign bus.ALUSrcB   = ctrl_s.alu_src_b;
  assign bus.ALUOp     = ctrl_s.alu_op;
  assign bus.MulStart  = mul_start_s;
  assign bus.MulHi     = mul_hi_s;
  assign bus.Illegal   = illegal_s;
  assign bus.state_o   = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: two instances (A: MUL_CYCLES=4, waits on;
// B: MUL_CYCLES=1, waits off) share stimulus; each scenario resets both
// and checks one. Expected state traces are built per instruction from the
// instruction-class rules; expected outputs come from the state table.
module tb_mc_ctrl_fsm;
  localparam int MC_A = 4;
  localparam int MC_B = 1;

  typedef struct packed {
    logic [3:0] st;
    logic       mrdy;
    logic       first;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm_if ifa ();
  mc_ctrl_fsm_if ifb ();

  mc_ctrl_fsm #(.MUL_CYCLES(MC_A), .MEM_WAIT_EN(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  mc_ctrl_fsm #(.MUL_CYCLES(MC_B), .MEM_WAIT_EN(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                       input logic mul, input logic lng, input logic rdy);
    ifa.Op = op; ifa.Funct = funct; ifa.is_mul = mul; ifa.is_long = lng; ifa.mem_ready = rdy;
    ifb.Op = op; ifb.Funct = funct; ifb.is_mul = mul; ifb.is_long = lng; ifb.mem_ready = rdy;
  endtask

  function automatic logic [3:0] obs_state(input int sel);
    return (sel == 0) ? ifa.state_o : ifb.state_o;
  endfunction

  // {IRWrite,AdrSrc,NextPC,RegW,MemW,Branch,ALUOp,ALUSrcA,ALUSrcB,ResultSrc,MulStart,MulHi,Illegal}
  function automatic logic [15:0] obs_out(input int sel);
    if (sel == 0)
      return {ifa.IRWrite, ifa.AdrSrc, ifa.NextPC, ifa.RegW, ifa.MemW, ifa.Branch, ifa.ALUOp,
              ifa.ALUSrcA, ifa.ALUSrcB, ifa.ResultSrc, ifa.MulStart, ifa.MulHi, ifa.Illegal};
    else
      return {ifb.IRWrite, ifb.AdrSrc, ifb.NextPC, ifb.RegW, ifb.MemW, ifb.Branch, ifb.ALUOp,
              ifb.ALUSrcA, ifb.ALUSrcB, ifb.ResultSrc, ifb.MulStart, ifb.MulHi, ifb.Illegal};
  endfunction

  // Output table straight from the state descriptions.
  function automatic logic [15:0] exp_out(input logic [3:0] st, input logic rdy,
                                          input logic first, input bit wait_en);
    logic ir, adr, npc, rw, mw, br, aop, ms, mh, ill, r;
    logic [1:0] sa, sb, rs;
    {ir, adr, npc, rw, mw, br, aop, ms, mh, ill} = 10'd0;
    sa = 2'd0; sb = 2'd0; rs = 2'd0;
    r = wait_en ? rdy : 1'b1;
    case (st)
      4'd0:  begin ir = r; npc = r; rs = 2'b10; sa = 2'b01; sb = 2'b10; end
      4'd1:  begin rs = 2'b10; sa = 2'b01; sb = 2'b10; end
      4'd2:  sb = 2'b01;
      4'd3:  adr = 1'b1;
      4'd4:  begin rw = 1'b1; rs = 2'b01; end
      4'd5:  begin mw = 1'b1; adr = 1'b1; end
      4'd6:  aop = 1'b1;
      4'd7:  begin sb = 2'b01; aop = 1'b1; end
      4'd8:  rw = 1'b1;
      4'd9:  begin br = 1'b1; rs = 2'b10; sb = 2'b01; end
      4'd10: ill = 1'b1;
      4'd11: begin aop = 1'b1; ms = first; end
      4'd12: rw = 1'b1;
      4'd13: begin rw = 1'b1; mh = 1'b1; end
      default: ;
    endcase
    return {ir, adr, npc, rw, mw, br, aop, sa, sb, rs, ms, mh, ill};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Run one instruction on instance sel starting in FETCH at a negedge.
  // wf/wm: wait cycles in FETCH and in MEMREAD/MEMWRITE (instance A only).
  task automatic run_instr(input int sel, input logic [1:0] op, input logic [5:0] funct,
                           input logic mul, input logic lng, input int wf, input int wm,
                           input string tag);
    ent_t q[$];
    int   mc, regw_exp, regw_seen, nf, nm;
    bit   we;
    logic [15:0] o, e;
    logic [3:0] s;
    mc = (sel == 0) ? MC_A : MC_B;
    we = (sel == 0);
    nf = we ? wf : 0;
    nm = we ? wm : 0;
    regw_seen = 0;
    regw_exp = 0;
    for (int i = 0; i < nf; i++) q.push_back('{4'd0, 1'b0, 1'b0});
    q.push_back('{4'd0, 1'b1, 1'b0});
    q.push_back('{4'd1, 1'($urandom), 1'b0});
    if (mul) begin
      for (int i = 0; i < mc; i++) q.push_back('{4'd11, 1'($urandom), (i == 0)});
      q.push_back('{4'd12, 1'($urandom), 1'b0});
      if (lng) q.push_back('{4'd13, 1'($urandom), 1'b0});
      regw_exp = lng ? 2 : 1;
    end else begin
      case (op)
        2'b00: begin
          q.push_back('{funct[5] ? 4'd7 : 4'd6, 1'($urandom), 1'b0});
          q.push_back('{4'd8, 1'($urandom), 1'b0});
          regw_exp = 1;
        end
        2'b01: begin
          q.push_back('{4'd2, 1'($urandom), 1'b0});
          for (int i = 0; i < nm; i++) q.push_back('{funct[0] ? 4'd3 : 4'd5, 1'b0, 1'b0});
          q.push_back('{funct[0] ? 4'd3 : 4'd5, 1'b1, 1'b0});
          if (funct[0]) begin
            q.push_back('{4'd4, 1'($urandom), 1'b0});
            regw_exp = 1;
          end
        end
        2'b10: q.push_back('{4'd9, 1'($urandom), 1'b0});
        default: q.push_back('{4'd10, 1'($urandom), 1'b0});
      endcase
    end
    // Instance B ignores mem_ready: randomise it everywhere.
    if (!we) foreach (q[k]) q[k].mrdy = 1'($urandom);
    foreach (q[k]) begin
      drive(op, funct, mul, lng, q[k].mrdy);
      #1;
      s = obs_state(sel);
      o = obs_out(sel);
      e = exp_out(q[k].st, q[k].mrdy, q[k].first, we);
      checks++;
      if (s !== q[k].st) begin
        errors++;
        $display("FAIL %s state cyc%0d: got %0d expected %0d", tag, k, s, q[k].st);
      end
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s outputs cyc%0d st%0d: got %b expected %b", tag, k, q[k].st, o, e);
      end
      if (o[12]) regw_seen++;
      @(negedge clk);
    end
    checks++;
    if (regw_seen != regw_exp) begin
      errors++;
      $display("FAIL %s regw_count: got %0d expected %0d", tag, regw_seen, regw_exp);
    end
  endtask

  task automatic test_reset();
    logic [15:0] o;
    drive(2'b00, 6'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ifa.state_o !== 4'd0 || ifb.state_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d/%0d expected 0/0", ifa.state_o, ifb.state_o);
    end
    o = obs_out(0);
    checks++;
    if (o !== exp_out(4'd0, 1'b0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL reset_out_a_nordy: got %b expected %b", o, exp_out(4'd0, 1'b0, 1'b0, 1'b1));
    end
    o = obs_out(1);
    checks++;
    if (o !== exp_out(4'd0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_out_b: got %b expected %b", o, exp_out(4'd0, 1'b0, 1'b0, 1'b0));
    end
    drive(2'b00, 6'd0, 1'b0, 1'b0, 1'b1);
    #1;
    o = obs_out(0);
    checks++;
    if (o !== exp_out(4'd0, 1'b1, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL reset_out_a_rdy: got %b expected %b", o, exp_out(4'd0, 1'b1, 1'b0, 1'b1));
    end
  endtask

  task automatic test_reset_mid_memwrite();
    logic [3:0] exp_seq[4];
    exp_seq[0] = 4'd0; exp_seq[1] = 4'd1; exp_seq[2] = 4'd2; exp_seq[3] = 4'd5;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 6'b000000, 1'b0, 1'b0, (k < 3) ? 1'b1 : 1'b0);
      #1;
      checks++;
      if (ifa.state_o !== exp_seq[k]) begin
        errors++;
        $display("FAIL rst_mw pre cyc%0d: got %0d expected %0d", k, ifa.state_o, exp_seq[k]);
      end
      if (k < 3) @(negedge clk);
    end
    checks++;
    if (ifa.MemW !== 1'b1) begin
      errors++;
      $display("FAIL rst_mw memw_held: got %b expected 1", ifa.MemW);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ifa.state_o !== 4'd0 || ifa.MemW !== 1'b0) begin
      errors++;
      $display("FAIL rst_mw abort: got state %0d MemW %b expected 0 0", ifa.state_o, ifa.MemW);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(2'b01, 6'b000000, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (ifa.state_o !== 4'd0 || ifa.MemW !== 1'b0) begin
      errors++;
      $display("FAIL rst_mw release_fetch: got %0d MemW %b expected 0 0", ifa.state_o, ifa.MemW);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ifa.state_o !== 4'd1) begin
      errors++;
      $display("FAIL rst_mw release_decode: got %0d expected 1", ifa.state_o);
    end
  endtask

  task automatic test_dp_reg();
    do_reset();
    run_instr(0, 2'b00, 6'b000000, 1'b0, 1'b0, 0, 0, "dp_reg");
  endtask

  task automatic test_load_wait();
    do_reset();
    run_instr(0, 2'b01, 6'b000001, 1'b0, 1'b0, 0, 2, "ldr_wait");
    run_instr(0, 2'b01, 6'b000000, 1'b0, 1'b0, 1, 1, "str_wait");
  endtask

  task automatic test_long_mul();
    do_reset();
    run_instr(0, 2'b00, 6'b000000, 1'b1, 1'b1, 0, 0, "long_mul4");
    run_instr(0, 2'b11, 6'b100000, 1'b1, 1'b0, 0, 0, "mul4");
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(0, 2'b11, 6'b000000, 1'b0, 1'b0, 0, 0, "illegal");
    run_instr(0, 2'b10, 6'b000000, 1'b0, 1'b0, 0, 0, "branch");
  endtask

  task automatic test_mul1();
    do_reset();
    run_instr(1, 2'b10, 6'b000000, 1'b1, 1'b0, 0, 0, "mul1");
    run_instr(1, 2'b00, 6'b100000, 1'b1, 1'b1, 0, 0, "long_mul1");
  endtask

  task automatic test_back_to_back();
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      for (int n = 0; n < 40; n++) begin
        run_instr(sel, 2'($urandom_range(0, 3)), 6'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2),
                  (sel == 0) ? "rand_a" : "rand_b");
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_memwrite();
    test_dp_reg();
    test_load_wait();
    test_long_mul();
    test_illegal();
    test_mul1();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
